// File: rtl/weight_mem_loader_pkg.sv
// Shared parameters, mode codes and FSM state type for the weight loader.
package weight_mem_loader_pkg;

  localparam logic [2:0] MODE_CNN = 3'd0;
  localparam logic [2:0] MODE_FC  = 3'd1;

  localparam int N_DIM_ARRAY             = 4;
  localparam int WEIGHT_DATA_WIDTH       = 8;
  localparam int WEIGHT_MEMORY_ADDR_SIZE = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } ld_state_t;

endpackage

// File: rtl/weight_mem_loader_if.sv
// Valid/ready weight stream into the loader.
interface weight_mem_loader_if #(
  parameter int DW = 8
);
  logic                 in_valid;
  logic signed [DW-1:0] in_data;
  logic                 in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/weight_mem_loader_row_packer.sv
// Shifts accepted weights into lanes; pulses row_full after the last lane.
module weight_row_packer #(
  parameter int N_DIM = 4,
  parameter int DW    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 beat,
  input  logic signed [DW-1:0] data,
  output logic signed [DW-1:0] row [N_DIM],
  output logic                 row_full,
  output logic                 last_lane
);

  localparam int LW = (N_DIM > 1) ? $clog2(N_DIM) : 1;

  logic [LW-1:0] lane;

  assign last_lane = (lane == LW'(N_DIM - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane     <= '0;
      row_full <= 1'b0;
      for (int i = 0; i < N_DIM; i++) row[i] <= '0;
    end else begin
      row_full <= beat && last_lane && !clear;
      if (clear) begin
        lane <= '0;
      end else if (beat) begin
        row[lane] <= data;
        lane      <= last_lane ? '0 : lane + LW'(1);
      end
    end
  end

endmodule

// File: rtl/weight_mem_loader.sv
// Streams weights into N_DIM-wide words for the FC or CNN weight memory.
// Define WEIGHT_LOADER_STALL_CNT_EN to build the starved-cycle counter.
module weight_mem_loader
  import weight_mem_loader_pkg::*;
#(
  parameter int N_DIM = N_DIM_ARRAY,
  parameter int DW    = WEIGHT_DATA_WIDTH,
  parameter int AW    = WEIGHT_MEMORY_ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2:0]           cfg_mode,
  input  logic                 cfg_bank,
  input  logic [AW-2:0]        cfg_base,
  input  logic [15:0]          cfg_num_words,
  weight_mem_loader_if.slave   in_s,
  output logic                 wr_en_ext_fc_w,
  output logic                 wr_en_ext_cnn_w,
  output logic [AW-1:0]        wr_addr_ext_fc_w,
  output logic [AW-1:0]        wr_addr_ext_cnn_w,
  output logic signed [DW-1:0] wr_data_ext_fc_w  [N_DIM],
  output logic signed [DW-1:0] wr_data_ext_cnn_w [N_DIM],
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          stall_cnt
);

  ld_state_t            state;
  logic                 ready;
  logic                 is_fc;
  logic                 bank;
  logic [AW-2:0]        base;
  logic [15:0]          num;
  logic [15:0]          acc_idx;
  logic [15:0]          wr_idx;
  logic [AW-2:0]        waddr_lo;
  logic                 start_ok;
  logic                 accept;
  logic                 last_acc;
  logic                 row_full;
  logic                 last_lane;
  logic signed [DW-1:0] row [N_DIM];

  assign in_s.in_ready = ready;
  assign start_ok      = start && (state == IDLE);
  // abort must beat a coincident final beat, so it gates acceptance
  assign accept        = in_s.in_valid && ready && !abort;
  assign last_acc      = accept && last_lane;
  assign waddr_lo      = base + wr_idx[AW-2:0];

  weight_row_packer #(
    .N_DIM (N_DIM),
    .DW    (DW)
  ) u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_ok || abort),
    .beat      (accept),
    .data      (in_s.in_data),
    .row       (row),
    .row_full  (row_full),
    .last_lane (last_lane)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ready   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      is_fc   <= 1'b0;
      bank    <= 1'b0;
      base    <= '0;
      num     <= '0;
      acc_idx <= '0;
      wr_idx  <= '0;
    end else if (abort) begin
      state <= IDLE;
      ready <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start_ok) begin
            is_fc   <= (cfg_mode == MODE_FC);
            bank    <= cfg_bank;
            base    <= cfg_base;
            num     <= cfg_num_words;
            acc_idx <= '0;
            wr_idx  <= '0;
            busy    <= 1'b1;
            if (cfg_num_words == 16'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= FILL;
              ready <= 1'b1;
            end
          end
        end
        FILL: begin
          if (last_acc) acc_idx <= acc_idx + 16'd1;
          if (last_acc && (acc_idx == num - 16'd1)) ready <= 1'b0;
          if (row_full) begin
            wr_idx <= wr_idx + 16'd1;
            if (wr_idx == num - 16'd1) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    wr_en_ext_fc_w    = 1'b0;
    wr_en_ext_cnn_w   = 1'b0;
    wr_addr_ext_fc_w  = '0;
    wr_addr_ext_cnn_w = '0;
    for (int i = 0; i < N_DIM; i++) begin
      wr_data_ext_fc_w[i]  = '0;
      wr_data_ext_cnn_w[i] = '0;
    end
    if (row_full && is_fc) begin
      wr_en_ext_fc_w   = 1'b1;
      wr_addr_ext_fc_w = {bank, waddr_lo};
      for (int i = 0; i < N_DIM; i++) wr_data_ext_fc_w[i] = row[i];
    end
    if (row_full && !is_fc) begin
      wr_en_ext_cnn_w   = 1'b1;
      wr_addr_ext_cnn_w = {bank, waddr_lo};
      for (int i = 0; i < N_DIM; i++) wr_data_ext_cnn_w[i] = row[i];
    end
  end

`ifdef WEIGHT_LOADER_STALL_CNT_EN
  // starved = loader ready but source has nothing to offer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (start_ok && !abort) begin
      stall_cnt <= '0;
    end else if (ready && !in_s.in_valid && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`else
  assign stall_cnt = '0;
`endif

endmodule
